sqr_wav_gen_mc: RTL and testbench

SQR_WAV_GEN_MC -- requirements
Module: sqr_wav_gen_mc

---
 rtl/sqr_wav_pkg.sv | 7 +
 rtl/sqr_wav_chan.sv | 81 ++++++++
 rtl/sqr_wav_gen_mc.sv | 30 +++
 tb/tb_sqr_wav_gen_mc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sqr_wav_pkg.sv
// sqr_wav_pkg: channel state encoding and default sizing shared by the square-wave generator.
package sqr_wav_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_TICK_DIV = 10;
endpackage

// File: rtl/sqr_wav_chan.sv
// sqr_wav_chan: one square-wave channel with shadowed high/low lengths applied at period boundaries.
module sqr_wav_chan
    import sqr_wav_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] low_i,
    output logic             sqr_o,
    output logic             done_o
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    state_e           state_q, state_d, start_st;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, act_hi_q, act_hi_d, act_lo_q, act_lo_d;
    logic [CNT_W-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d, len, nxt_hi, nxt_lo;
    logic             pend_q, pend_d, sqr_q, sqr_d, done_q, done_d;
    logic             tick_end, ph_end, bnd, upd;

    always_comb begin
        tick_end = pre_q == PW'(TICK_DIV - 1);
        len      = (state_q == HIGH) ? act_hi_q : act_lo_q;
        ph_end   = tick_end && (cnt_q == len - CNT_W'(1));
        // A period ends after LOW, or after HIGH when there is no LOW phase
        bnd      = ph_end && ((state_q == LOW) || (state_q == HIGH && act_lo_q == '0));
        upd      = en_i && ((state_q == IDLE) || bnd);
        nxt_hi   = pend_q ? sh_hi_q : act_hi_q;
        nxt_lo   = pend_q ? sh_lo_q : act_lo_q;
        start_st = (nxt_hi != '0) ? HIGH : (nxt_lo != '0) ? LOW : IDLE;
        state_d  = state_q;
        pre_d    = tick_end ? '0 : pre_q + PW'(1);
        cnt_d    = tick_end ? cnt_q + CNT_W'(1) : cnt_q;
        if (!en_i || upd || ph_end) begin
            state_d = !en_i ? IDLE : upd ? start_st : LOW;
            pre_d   = '0;
            cnt_d   = '0;
        end
        act_hi_d = upd ? nxt_hi : act_hi_q;
        act_lo_d = upd ? nxt_lo : act_lo_q;
        sh_hi_d  = load_i ? high_i : sh_hi_q;
        sh_lo_d  = load_i ? low_i : sh_lo_q;
        pend_d   = load_i || (pend_q && !upd);
        done_d   = en_i && bnd;
        sqr_d    = state_d == HIGH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            act_hi_q <= '0;
            act_lo_q <= '0;
            sh_hi_q  <= '0;
            sh_lo_q  <= '0;
            pend_q   <= 1'b0;
            sqr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            act_hi_q <= act_hi_d;
            act_lo_q <= act_lo_d;
            sh_hi_q  <= sh_hi_d;
            sh_lo_q  <= sh_lo_d;
            pend_q   <= pend_d;
            sqr_q    <= sqr_d;
            done_q   <= done_d;
        end
    end

    assign sqr_o  = sqr_q;
    assign done_o = done_q;
endmodule

// File: rtl/sqr_wav_gen_mc.sv
// sqr_wav_gen_mc: NUM_CH independent programmable square-wave channels.
module sqr_wav_gen_mc
    import sqr_wav_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            en,
    input  logic [NUM_CH-1:0][CNT_W-1:0] high_m,
    input  logic [NUM_CH-1:0][CNT_W-1:0] low_n,
    input  logic [NUM_CH-1:0]            load,
    output logic [NUM_CH-1:0]            sqr_out,
    output logic [NUM_CH-1:0]            period_done
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sqr_wav_chan #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en[i]),
            .load_i (load[i]),
            .high_i (high_m[i]),
            .low_i  (low_n[i]),
            .sqr_o  (sqr_out[i]),
            .done_o (period_done[i])
        );
    end
endmodule

// File: tb/tb_sqr_wav_gen_mc.sv
// tb_sqr_wav_gen_mc: scoreboard of expected edge/pulse cycle numbers checked against the DUT.
module tb_sqr_wav_gen_mc;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int TD = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N-1:0]         en = '0;
    logic [N-1:0]         load = '0;
    logic [N-1:0][CW-1:0] high_m = '0;
    logic [N-1:0][CW-1:0] low_n = '0;
    logic [N-1:0]         sqr_out, period_done;
    logic [N-1:0]         prev = '0;
    int                   cyc = 0;
    int                   checks = 0;
    int                   failures = 0;
    int                   qd[N][$];
    int                   qe[N][$];

    sqr_wav_gen_mc #(.NUM_CH(N), .CNT_W(CW), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .high_m      (high_m),
        .low_n       (low_n),
        .load        (load),
        .sqr_out     (sqr_out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Every done pulse and every sqr_out transition must match the next queued cycle number
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_n) begin
                if (period_done[i]) begin
                    if (qd[i].size() > 0) chk($sformatf("done_ch%0d", i), cyc, qd[i].pop_front());
                    else chk($sformatf("done_unexp_ch%0d", i), cyc, -1);
                end
                if (sqr_out[i] != prev[i]) begin
                    if (qe[i].size() > 0) chk($sformatf("edge_ch%0d", i), cyc, qe[i].pop_front());
                    else chk($sformatf("edge_unexp_ch%0d", i), cyc, -1);
                end
            end
            prev[i] = sqr_out[i];
        end
    end

    task automatic push_run(int ch, int s, int h, int l, int lim);
        for (int t0 = s; t0 < lim; t0 += (h + l) * TD) begin
            if (h > 0) qe[ch].push_back(t0);
            if (h > 0 && t0 + h * TD <= lim) qe[ch].push_back(t0 + h * TD);
            if (t0 + (h + l) * TD <= lim) qd[ch].push_back(t0 + (h + l) * TD);
        end
    endtask

    task automatic wait_to(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_ch(int ch, int h, int l);
        high_m[ch] = CW'(h);
        low_n[ch]  = CW'(l);
        load[ch]   = 1'b1;
        @(posedge clk);
        #1;
        load[ch] = 1'b0;
    endtask

    task automatic drained(string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_left_ch%0d", tag, i), qd[i].size() + qe[i].size(), 0);
    endtask

    initial begin
        int s, k;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sqr", int'(sqr_out), 0);
        chk("rst_done", int'(period_done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // 3/2 run, reload to 1/1 mid-HIGH, then drop en during LOW
        load_ch(0, 3, 2);
        en[0] = 1'b1;
        s = cyc + 1;
        k = s + 175;
        push_run(0, s, 3, 2, s + 100);
        push_run(0, s + 100, 1, 1, k);
        wait_to(s + 55);
        load_ch(0, 1, 1);
        wait_to(k);
        en[0] = 1'b0;
        wait_to(k + 20);
        chk("a_off_sqr", int'(sqr_out[0]), 0);
        drained("a");
        en[0] = 1'b1;
        s = cyc + 1;
        push_run(0, s, 1, 1, s + 35);
        wait_to(s + 35);
        en[0] = 1'b0;
        wait_to(s + 50);
        drained("a2");
        // high=0 runs LOW-only periods; then 0/0 stops after the current period
        load_ch(1, 0, 4);
        en[1] = 1'b1;
        s = cyc + 1;
        push_run(1, s, 0, 4, s + 80);
        wait_to(s + 50);
        load_ch(1, 0, 0);
        wait_to(s + 300);
        en[1] = 1'b0;
        chk("b_sqr", int'(sqr_out[1]), 0);
        drained("b");
        // Full-width high phase, en dropped mid-HIGH
        load_ch(2, 255, 1);
        en[2] = 1'b1;
        s = cyc + 1;
        k = s + 2565;
        push_run(2, s, 255, 1, k);
        qe[2].push_back(k + 1);
        wait_to(k);
        en[2] = 1'b0;
        wait_to(k + 10);
        drained("c");
        // All channels together, then asynchronous reset mid-run
        for (int i = 0; i < N; i++) begin
            high_m[i] = CW'(i + 1);
            low_n[i]  = CW'(i + 1);
        end
        load = '1;
        @(posedge clk);
        #1;
        load = '0;
        en = '1;
        s = cyc + 1;
        k = s + 135;
        for (int i = 0; i < N; i++) push_run(i, s, i + 1, i + 1, k);
        wait_to(k);
        chk("d_pre_sqr", int'(sqr_out), 6);
        rst_n = 1'b0;
        #1;
        chk("d_rst_sqr", int'(sqr_out), 0);
        chk("d_rst_done", int'(period_done), 0);
        drained("d");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = cyc;
        wait_to(s + 100);
        chk("d_idle_sqr", int'(sqr_out), 0);
        drained("d2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
